// File: rtl/calc_controller.sv
// Calculator sequencer: collects two signed decimal operands from the keypad,
// launches one ALU operation per equals key and shows the operand or result being worked on.
module calc_controller (
  input  logic        clk,
  input  logic        nRST,
  input  logic        read_input,
  output logic        key_read,
  input  logic [3:0]  keypad_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_ovf,
  output logic [15:0] display_value,
  output logic        error
);

  typedef enum logic [2:0] {ENTRY_A, ENTRY_B, EXEC, WAIT_ALU, RESULT, ERROR} state_t;

  localparam logic [2:0] OP_NEG = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  state_t             state, state_nx;
  logic signed [15:0] a, a_nx, b, b_nx;
  logic [2:0]         op, op_nx;
  logic               b_entered, b_entered_nx;
  logic               key_read_nx;
  logic [15:0]        alu_a_nx, alu_b_nx;
  logic [2:0]         alu_op_nx;
  logic               take_key, is_digit, is_oper, is_neg, is_binop;

  // Shift a decimal digit into a signed operand by magnitude; digits that would
  // push the magnitude past 32767 leave the operand untouched.
  function automatic logic signed [15:0] push_digit(input logic signed [15:0] v,
                                                    input logic [3:0] d);
    logic [16:0] mag;
    logic [20:0] acc;
    logic signed [15:0] res;
    mag = v[15] ? (~{1'b1, v} + 17'd1) : {1'b0, v};
    acc = {4'd0, mag} * 21'd10 + {17'd0, d};
    res = v;
    if (acc <= 21'd32767)
      res = v[15] ? -$signed(acc[15:0]) : $signed(acc[15:0]);
    return res;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_nx     = state;
    a_nx         = a;
    b_nx         = b;
    op_nx        = op;
    b_entered_nx = b_entered;
    alu_a_nx     = alu_a;
    alu_b_nx     = alu_b;
    alu_op_nx    = alu_op;

    take_key = (state inside {ENTRY_A, ENTRY_B, RESULT, ERROR}) && read_input && !key_read;
    is_digit = !equal_input && (operator_input == 3'b000);
    is_oper  = !equal_input && (operator_input != 3'b000);
    is_neg   = is_oper && (operator_input == OP_NEG);
    is_binop = is_oper && (operator_input inside {OP_ADD, OP_SUB, OP_MUL});

    // An open handshake always runs to completion, even across EXEC/WAIT_ALU.
    key_read_nx = key_read ? read_input : take_key;

    unique case (state)
      ENTRY_A, RESULT: if (take_key) begin
        if (is_digit)
          a_nx = (state == RESULT) ? $signed({12'd0, keypad_input}) : push_digit(a, keypad_input);
        else if (is_neg)
          a_nx = -a;
        else if (is_binop) begin
          op_nx        = operator_input;
          b_nx         = '0;
          b_entered_nx = 1'b0;
          state_nx     = ENTRY_B;
        end
        if (state == RESULT && is_digit)
          state_nx = ENTRY_A;
      end
      ENTRY_B: if (take_key) begin
        if (equal_input) begin
          alu_a_nx  = a;
          alu_b_nx  = b;
          alu_op_nx = op;
          state_nx  = EXEC;
        end else if (is_digit) begin
          b_nx         = push_digit(b, keypad_input);
          b_entered_nx = 1'b1;
        end else if (is_neg)
          b_nx = -b;
        else if (is_binop && !b_entered)
          op_nx = operator_input;
      end
      EXEC: state_nx = WAIT_ALU;
      WAIT_ALU: if (alu_done) begin
        if (alu_ovf)
          state_nx = ERROR;
        else begin
          a_nx     = alu_result;
          state_nx = RESULT;
        end
      end
      ERROR: if (take_key) begin
        a_nx         = '0;
        b_nx         = '0;
        b_entered_nx = 1'b0;
        state_nx     = ENTRY_A;
      end
      default: state_nx = ENTRY_A;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= ENTRY_A;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      b_entered <= 1'b0;
      key_read  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_nx;
      a         <= a_nx;
      b         <= b_nx;
      op        <= op_nx;
      b_entered <= b_entered_nx;
      key_read  <= key_read_nx;
      alu_a     <= alu_a_nx;
      alu_b     <= alu_b_nx;
      alu_op    <= alu_op_nx;
    end
  end

  assign alu_start = (state == EXEC);
  assign error     = (state == ERROR);

  always_comb begin
    display_value = a;
    unique case (state)
      ENTRY_B: display_value = b_entered ? b : a;
      ERROR:   display_value = '0;
      default: display_value = a;
    endcase
  end

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: keypad handshake, operand entry limits,
// ALU launch/hold, overflow error path and reset during an ALU wait.
module tb_calc_controller;

  logic        clk = 1'b0;
  logic        nRST;
  logic        read_input, key_read;
  logic [3:0]  keypad_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic [15:0] alu_a, alu_b, alu_result, display_value;
  logic [2:0]  alu_op;
  logic        alu_start, alu_done, alu_ovf, error;

  int          n_cmp = 0;
  int          n_err = 0;
  int          start_cnt = 0;
  logic [15:0] cap_a, cap_b;
  logic [2:0]  cap_op;

  localparam logic [2:0] NEG = 3'b001, ADD = 3'b010, SUB = 3'b011, MUL = 3'b100;

  calc_controller dut (
    .clk(clk), .nRST(nRST), .read_input(read_input), .key_read(key_read),
    .keypad_input(keypad_input), .operator_input(operator_input), .equal_input(equal_input),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .display_value(display_value), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (alu_start) begin
      start_cnt = start_cnt + 1;
      cap_a  = alu_a;
      cap_b  = alu_b;
      cap_op = alu_op;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_kr(input logic v, input string tag);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (key_read === v) break;
    end
    check(tag, {31'd0, key_read}, {31'd0, v});
  endtask

  task automatic press(input logic [3:0] d, input logic [2:0] op, input logic eq);
    keypad_input = d; operator_input = op; equal_input = eq; read_input = 1'b1;
    wait_kr(1'b1, "key_ack");
    read_input = 1'b0;
    wait_kr(1'b0, "key_release");
    keypad_input = '0; operator_input = '0; equal_input = 1'b0;
  endtask

  task automatic alu_reply(input logic [15:0] r, input logic ovf, input int lead);
    repeat (lead) @(posedge clk);
    #1;
    alu_done = 1'b1; alu_result = r; alu_ovf = ovf;
    @(posedge clk); #1;
    alu_done = 1'b0; alu_result = '0; alu_ovf = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    start_cnt = 0;
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    nRST = 1'b0; read_input = 1'b0; keypad_input = '0; operator_input = '0;
    equal_input = 1'b0; alu_done = 1'b0; alu_result = '0; alu_ovf = 1'b0;
    #1;
    check("rst_display", {16'd0, display_value}, 32'd0);
    check("rst_outputs", {alu_a, alu_b}, 32'd0);
    check("rst_ctrl", {26'd0, alu_op, alu_start, key_read, error}, 32'd0);
    do_reset();

    // 12 + 34 = 46
    press(4'd1, 3'd0, 1'b0);
    check("a_digit1", {16'd0, display_value}, 32'd1);
    press(4'd2, 3'd0, 1'b0);
    press(4'd0, ADD, 1'b0);
    check("b_empty_shows_a", {16'd0, display_value}, 32'd12);
    press(4'd3, 3'd0, 1'b0);
    press(4'd4, 3'd0, 1'b0);
    check("b_entry", {16'd0, display_value}, 32'd34);
    press(4'd0, 3'd0, 1'b1);
    check("one_start", start_cnt, 32'd1);
    check("alu_args", {cap_a, cap_b}, {16'd12, 16'd34});
    check("alu_op_add", {29'd0, cap_op}, {29'd0, ADD});
    check("wait_shows_a", {16'd0, display_value}, 32'd12);
    @(posedge clk); #1;
    check("alu_hold", {alu_a, alu_b}, {16'd12, 16'd34});
    alu_reply(16'd46, 1'b0, 1);
    check("result_46", {16'd0, display_value}, 32'd46);
    check("still_one_start", start_cnt, 32'd1);
    check("no_error", {31'd0, error}, 32'd0);

    // Long press of digit 7 from RESULT
    keypad_input = 4'd7; operator_input = '0; equal_input = 1'b0; read_input = 1'b1;
    check("kr_before_edge", {31'd0, key_read}, 32'd0);
    @(posedge clk); #1;
    check("kr_rise", {31'd0, key_read}, 32'd1);
    repeat (19) @(posedge clk);
    #1;
    check("held_key_once", {16'd0, display_value}, 32'd7);
    check("kr_held", {31'd0, key_read}, 32'd1);
    read_input = 1'b0;
    @(posedge clk); #1;
    check("kr_fall", {31'd0, key_read}, 32'd0);
    check("a_is_7", {16'd0, dut.a}, 32'd7);

    // Magnitude limit
    do_reset();
    press(4'd3, 3'd0, 1'b0);
    press(4'd2, 3'd0, 1'b0);
    press(4'd7, 3'd0, 1'b0);
    press(4'd6, 3'd0, 1'b0);
    press(4'd8, 3'd0, 1'b0);
    check("reject_32768", {16'd0, display_value}, 32'd3276);
    press(4'd9, 3'd0, 1'b0);
    check("reject_32769", {16'd0, display_value}, 32'd3276);
    press(4'd0, NEG, 1'b0);
    check("neg_3276", {16'd0, display_value}, {16'd0, 16'hF334});
    press(4'd7, 3'd0, 1'b0);
    check("neg_limit_-32767", {16'd0, display_value}, {16'd0, 16'h8001});
    press(4'd0, 3'd0, 1'b0);
    check("neg_reject", {16'd0, display_value}, {16'd0, 16'h8001});

    // Overflow -> ERROR -> cleared by next key
    do_reset();
    press(4'd0, NEG, 1'b0);
    check("neg_zero", {16'd0, display_value}, 32'd0);
    press(4'd5, 3'd0, 1'b0);
    press(4'd0, NEG, 1'b0);
    press(4'd0, MUL, 1'b0);
    check("entry_b_shows_-5", {16'd0, display_value}, {16'd0, 16'hFFFB});
    press(4'd3, 3'd0, 1'b0);
    press(4'd0, 3'd0, 1'b1);
    check("mul_args", {cap_a, cap_b}, {16'hFFFB, 16'd3});
    check("mul_op", {29'd0, cap_op}, {29'd0, MUL});
    alu_reply(16'h1234, 1'b1, 2);
    check("err_flag", {31'd0, error}, 32'd1);
    check("err_display", {16'd0, display_value}, 32'd0);
    press(4'd4, 3'd0, 1'b0);
    check("err_cleared", {31'd0, error}, 32'd0);
    check("err_key_dropped", {16'd0, display_value}, 32'd0);
    press(4'd8, 3'd0, 1'b0);
    check("entry_a_after_err", {16'd0, display_value}, 32'd8);
    alu_reply(16'd99, 1'b0, 0);
    check("stray_done_ignored", {16'd0, display_value}, 32'd8);

    // Operator replacement and key blocked during WAIT_ALU
    do_reset();
    press(4'd9, 3'd0, 1'b0);
    press(4'd0, ADD, 1'b0);
    press(4'd0, SUB, 1'b0);
    press(4'd4, 3'd0, 1'b0);
    press(4'd0, MUL, 1'b0);
    press(4'd0, 3'd0, 1'b1);
    check("sub_args", {cap_a, cap_b}, {16'd9, 16'd4});
    check("op_replaced", {29'd0, cap_op}, {29'd0, SUB});
    keypad_input = 4'd6; read_input = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_kr_in_wait", {31'd0, key_read}, 32'd0);
    alu_reply(16'd5, 1'b0, 0);
    check("result_5", {16'd0, display_value}, 32'd5);
    check("kr_not_yet", {31'd0, key_read}, 32'd0);
    wait_kr(1'b1, "kr_in_result");
    check("pending_digit", {16'd0, display_value}, 32'd6);
    read_input = 1'b0;
    wait_kr(1'b0, "kr_release_result");

    // Reset mid-WAIT_ALU
    do_reset();
    press(4'd1, 3'd0, 1'b0);
    press(4'd0, ADD, 1'b0);
    press(4'd2, 3'd0, 1'b0);
    press(4'd0, 3'd0, 1'b1);
    #3;
    nRST = 1'b0;
    #1;
    check("async_rst_alu", {alu_a, alu_b}, 32'd0);
    check("async_rst_ctrl", {26'd0, alu_op, alu_start, key_read, error}, 32'd0);
    check("async_rst_display", {16'd0, display_value}, 32'd0);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk); #1;
    alu_reply(16'd77, 1'b0, 0);
    check("late_done_display", {16'd0, display_value}, 32'd0);
    check("late_done_a", {16'd0, dut.a}, 32'd0);
    check("late_done_ctrl", {26'd0, alu_op, alu_start, key_read, error}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
